// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
`default_nettype none

package writeback_arbiter_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
  localparam int MAX_REQ = 8;

  function automatic logic at_least_two(input logic [MAX_REQ-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (vec[i]) cnt++;
    end
    return (cnt >= 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int PW1   = PTR_W + 1;

  logic [PTR_W:0] idx;
  logic           found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = {1'b0, ptr} + PW1'(off);
      if (idx >= PW1'(NUM_REQ)) idx = idx - PW1'(NUM_REQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        found                  = 1'b1;
        grant[idx[PTR_W-1:0]]  = 1'b1;
        winner                 = idx[PTR_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// Per-source one-entry buffers drained round-robin onto a registered register-file write port.
`default_nettype none

module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [REG_ADDR_WIDTH*NUM_REQ-1:0] req_reg,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]    req_data,
  output logic                             write,
  output logic [REG_ADDR_WIDTH-1:0]        write_reg,
  output logic [DATA_WIDTH-1:0]            write_data,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             conflict_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || CORE < 0) begin : g_param_check
    $error("writeback_arbiter: unsupported parameter set");
  end

  logic [NUM_REQ-1:0]        buf_v;
  logic [REG_ADDR_WIDTH-1:0] buf_reg  [NUM_REQ];
  logic [DATA_WIDTH-1:0]     buf_data [NUM_REQ];
  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          winner;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        accept;
  logic                      any_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req    (buf_v),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  assign any_grant = |grant;
  assign req_ready = ~buf_v | grant;
  assign accept    = req_valid & req_ready;
  assign busy      = |buf_v;

  // Writes to x0 complete the handshake but never occupy a buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_v <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_reg[i]  <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i] && (req_reg[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != REG_ZERO)) begin
          buf_v[i]    <= 1'b1;
          buf_reg[i]  <= req_reg[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
          buf_data[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (grant[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write      <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (any_grant) begin
      write      <= 1'b1;
      write_reg  <= buf_reg[winner];
      write_data <= buf_data[winner];
    end else begin
      write <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_count <= '0;
    end else if (at_least_two(MAX_REQ'(buf_v)) && (conflict_count != '1)) begin
      conflict_count <= conflict_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed traffic, port writes checked against queued expectations.
`default_nettype none

module tb_writeback_arbiter;

  typedef struct {
    logic [4:0]  rg;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic        write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        busy;
  logic [15:0] conflict_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   log_mode = 0;
  exp_t exp_q[$];
  exp_t obs_q[$];

  writeback_arbiter #(
    .CORE(0), .DATA_WIDTH(32), .NUM_REQ(3), .CNT_WIDTH(16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_reg        (req_reg),
    .req_data       (req_data),
    .write          (write),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .busy           (busy),
    .conflict_count (conflict_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  task automatic set_src(input int s, input logic v, input logic [4:0] r, input logic [31:0] d);
    req_valid[s]       = v;
    req_reg[s*5 +: 5]  = r;
    req_data[s*32 +: 32] = d;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] r, input logic [31:0] d, input int c);
    exp_q.push_back('{rg: r, data: d, cyc: c});
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (write) begin
      if (log_mode) begin
        obs_q.push_back('{rg: write_reg, data: write_data, cyc: cyc});
      end else if (exp_q.size() == 0) begin
        check("unexp_write", 64'(write), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_reg", 64'(write_reg), 64'(e.rg));
        check("wr_data", 64'(write_data), 64'(e.data));
        check("wr_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin : stim
    int   k;
    logic [15:0] cc0;
    exp_t q0[$];
    exp_t q2[$];
    exp_t e;
    int   n0, n2, w0, w2;

    reset = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_write", 64'(write), 0);
    check("rst_wreg", 64'(write_reg), 0);
    check("rst_wdata", 64'(write_data), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_cc", 64'(conflict_count), 0);
    check("rst_ready", 64'(req_ready), 64'h7);
    reset = 1'b1;
    next_cycle();

    // three-way contention from rr_ptr=0
    k = cyc; cc0 = conflict_count;
    set_src(0, 1, 10, 32'h1000_000A);
    set_src(1, 1, 11, 32'h1000_000B);
    set_src(2, 1, 12, 32'h1000_000C);
    expect_write(10, 32'h1000_000A, k + 2);
    expect_write(11, 32'h1000_000B, k + 3);
    expect_write(12, 32'h1000_000C, k + 4);
    @(negedge clock); check("3w_ready_t0", 64'(req_ready), 64'h7);
    next_cycle(); req_valid = '0;
    @(negedge clock); check("3w_ready_t1", 64'(req_ready), 64'h1);
    check("3w_busy_t1", 64'(busy), 1);
    next_cycle();
    @(negedge clock); check("3w_ready_t2", 64'(req_ready), 64'h3);
    repeat (4) next_cycle();
    check("3w_cc", 64'(conflict_count - cc0), 2);
    check("3w_drain", 64'(exp_q.size()), 0);

    // single source, single write; inputs change while idle and must be ignored
    k = cyc;
    set_src(1, 1, 5, 32'hDEAD_BEEF);
    expect_write(5, 32'hDEAD_BEEF, k + 2);
    @(negedge clock); check("single_busy_t0", 64'(busy), 0);
    next_cycle(); set_src(1, 0, 9, 32'h0BAD_0BAD);
    @(negedge clock); check("single_busy_t1", 64'(busy), 1);
    next_cycle();
    @(negedge clock); check("single_busy_t2", 64'(busy), 0);
    repeat (3) next_cycle();
    check("single_drain", 64'(exp_q.size()), 0);

    // back-to-back from one source
    k = cyc;
    for (int n = 0; n < 3; n++) begin
      set_src(0, 1, 5'(n + 1), 32'h0000_0100 + n);
      expect_write(5'(n + 1), 32'h0000_0100 + n, k + n + 2);
      @(negedge clock); check("b2b_ready", 64'(req_ready[0]), 1);
      next_cycle();
    end
    req_valid = '0;
    repeat (4) next_cycle();
    check("b2b_drain", 64'(exp_q.size()), 0);

    // sustained contention between sources 0 and 2 (odd regs from 0, even from 2)
    log_mode = 1; obs_q.delete(); cc0 = conflict_count; n0 = 0; n2 = 0;
    for (int c = 0; c < 10; c++) begin
      set_src(0, 1, 5'(2 * n0 + 1), 32'hA000_0000 + n0);
      set_src(2, 1, 5'(2 * n2 + 2), 32'hC000_0000 + n2);
      @(negedge clock);
      if (req_ready[0]) begin q0.push_back('{rg: 5'(2 * n0 + 1), data: 32'hA000_0000 + n0, cyc: 0}); n0++; end
      if (req_ready[2]) begin q2.push_back('{rg: 5'(2 * n2 + 2), data: 32'hC000_0000 + n2, cyc: 0}); n2++; end
      next_cycle();
    end
    req_valid = '0;
    repeat (5) next_cycle();
    log_mode = 0;
    check("sus_count", 64'(obs_q.size()), 64'(n0 + n2));
    w0 = 0; w2 = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].rg[0]) begin
        w0++;
        if (q0.size() == 0) check("sus_src0_extra", 64'(obs_q[i].rg), 0);
        else begin e = q0.pop_front(); check("sus_src0_data", 64'(obs_q[i].data), 64'(e.data)); check("sus_src0_reg", 64'(obs_q[i].rg), 64'(e.rg)); end
      end else begin
        w2++;
        if (q2.size() == 0) check("sus_src2_extra", 64'(obs_q[i].rg), 0);
        else begin e = q2.pop_front(); check("sus_src2_data", 64'(obs_q[i].data), 64'(e.data)); check("sus_src2_reg", 64'(obs_q[i].rg), 64'(e.rg)); end
      end
      if (i > 0) begin
        check("sus_alternate", 64'(obs_q[i].rg[0] ^ obs_q[i-1].rg[0]), 1);
        check("sus_no_gap", 64'(obs_q[i].cyc - obs_q[i-1].cyc), 1);
      end
    end
    check("sus_min_src0", 64'(w0 >= 4), 1);
    check("sus_min_src2", 64'(w2 >= 4), 1);
    check("sus_cc", 64'(conflict_count - cc0), 10);

    // write to x0 is dropped
    set_src(2, 1, 0, 32'h0000_1234);
    @(negedge clock); check("x0_ready", 64'(req_ready[2]), 1);
    next_cycle(); set_src(2, 0, 0, 0);
    @(negedge clock); check("x0_busy_t1", 64'(busy), 0);
    next_cycle();
    @(negedge clock); check("x0_busy_t2", 64'(busy), 0);
    check("x0_write_t2", 64'(write), 0);
    repeat (3) next_cycle();

    // async reset with all buffers loaded and a write on the port
    set_src(0, 1, 7, 32'h7777_7777);
    set_src(1, 1, 8, 32'h8888_8888);
    set_src(2, 1, 9, 32'h9999_9999);
    next_cycle(); req_valid = '0;
    next_cycle();
    check("rst_pre_write", 64'(write), 1);
    check("rst_pre_busy", 64'(busy), 1);
    #1 reset = 1'b0;
    #1;
    check("arst_write", 64'(write), 0);
    check("arst_busy", 64'(busy), 0);
    check("arst_cc", 64'(conflict_count), 0);
    check("arst_ready", 64'(req_ready), 64'h7);
    next_cycle();
    reset = 1'b1;
    repeat (3) next_cycle();
    k = cyc;
    set_src(0, 1, 4, 32'h4444_0000);
    set_src(2, 1, 3, 32'h3333_0000);
    expect_write(4, 32'h4444_0000, k + 2);
    expect_write(3, 32'h3333_0000, k + 3);
    next_cycle(); req_valid = '0;
    repeat (5) next_cycle();
    check("post_rst_drain", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Shares the single register-file write port between NUM_REQ writeback sources: ALU result, load return and multi-cycle unit, indexed 0..NUM_REQ-1. Each source gets a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter drains the buffers onto a registered write/write_reg/write_data port that feeds the register file. The block sits between the writeback mux stage and the register file, and also exports busy and contention status for the pipeline and perf logging.

Parameters:
CORE, 0, core index, carried for multi-core instantiation
DATA_WIDTH, 32, width of write data
NUM_REQ, 3, number of writeback sources (2..8)
CNT_WIDTH, 16, width of the contention counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  source i presents a write
req_ready  output  NUM_REQ  source i write accepted this cycle when valid&ready
req_reg  input  5*NUM_REQ  destination register, source i at bits [5i+4:5i]
req_data  input  DATA_WIDTH*NUM_REQ  write data, source i at slice i
write  output  1  register-file write enable
write_reg  output  5  register-file write address
write_data  output  DATA_WIDTH  register-file write data
busy  output  1  any holding buffer valid
conflict_count  output  CNT_WIDTH  saturating count of cycles with ≥2 buffers valid

Behaviour:
- Reset (reset=0, asynchronous):
  - all buffers invalid; rr_ptr=0
  - write=0, write_reg=0, write_data=0
  - conflict_count=0; busy=0; req_ready all 1
- Per-source buffer: buf_v[i], buf_reg[i], buf_data[i].
  - req_ready[i] = ~buf_v[i] | grant[i], which is combinational from registered state and never depends on req_valid.
  - Accept = req_valid[i] & req_ready[i]. The buffer loads at the next edge.
  - If the accepted req_reg==0, the write is dropped: the buffer is not loaded, the handshake still completes, and no port write occurs.
  - Granted and not refilled → buf_v[i] clears at the edge. Granted and accept in the same cycle → the buffer reloads. This gives 1 write/cycle for a sole active source.
- Arbitration, combinational over buf_v:
  - The first valid index searching upward from rr_ptr, wrapping at NUM_REQ-1→0, wins. Exactly one grant, or none.
  - On a grant, rr_ptr <= winner+1, wrapping to 0 after NUM_REQ-1. With no grant, rr_ptr holds.
- Output register:
  - On a grant: write<=1, write_reg<=buf_reg[w], write_data<=buf_data[w].
  - Otherwise write<=0 and write_reg/write_data hold their last values.
  - Latency: valid accepted in cycle t → write=1 in cycle t+2 earliest (t+1 buffered/arbitrated, t+2 registered out).
- Ordering:
  - Writes from the same source reach the port in acceptance order.
  - No ordering is guaranteed between different sources. Same-register hazards across sources are resolved upstream by the hazard unit.
- Fairness: with all NUM_REQ buffers continuously valid, each source is granted exactly once per NUM_REQ cycles.
- Status outputs:
  - busy = |buf_v.
  - conflict_count increments by 1 at each edge where popcount(buf_v)≥2, and saturates at all-ones.
- Reset mid-operation: pending buffered writes are discarded, not written. An in-flight output write is cleared asynchronously.
- req_reg/req_data are sampled only on accept. Changes while req_valid=0 or req_ready=0 are ignored.

Decomposition:
- Shared package:
  - REG_ADDR_WIDTH=5
  - REG_ZERO=5'd0
  - helper function for popcount≥2
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and ptr, outputs one-hot grant plus encoded winner index, purely combinational.
- writeback_arbiter owns the buffers, pointer, output register and counter.

Test Plan:
- Single source: source 1 sends reg 5/data 0xDEADBEEF in cycle 0 → write=1, write_reg=5, write_data=0xDEADBEEF in cycle 2 only; busy high in cycle 1 only.
- Back-to-back single source: source 0 sends regs 1,2,3 in cycles 0-2 with req_ready held 1 → writes at cycles 2,3,4 in order; no gaps.
- Three-way contention: all three sources send one write in cycle 0 (regs 10,11,12) → writes to 10,11,12 in cycles 2,3,4 (rr_ptr=0 start); req_ready[1]=0 and req_ready[2]=0 while buffered; conflict_count=2 afterwards.
- Sustained contention: sources 0 and 2 hold valid continuously for 10 cycles → grants strictly alternate 0,2,0,2; each gets ≥4 writes; conflict_count increments each overlapping cycle.
- x0 drop: source 2 sends reg 0/data 0x1234 → req_ready=1, busy stays 0, write never asserts.
- Async reset mid-flight: three buffers valid, reset low mid-cycle → write, busy and conflict_count go 0 immediately. After release no pending write appears and a new request yields write at +2 cycles with rr_ptr=0 priority.
